vec_op_sequencer: RTL and testbench
===================================

Name: vec_op_sequencer

Overview:
- Executes the operation selected by the command decoder FSM: sequences vector-memory addresses, UART RX/TX byte handshakes and the arithmetic datapath strobes for each opcode.
- Pulses op_finished on completion so the decoder returns to idle.
- Sits between the decoder, the two vector BRAMs (A, B), the element ALU / distance accumulator and the UART.

Parameters:
N, 1024, vector length in elements
AW, $clog2(N), memory address width
ELEM_BYTES, 2, TX bytes per element result for sumVec/avgVec (MSB first)
RES_W, 24, distance result width
RES_BYTES, 3, TX bytes for distance result (MSB first)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
op  in  8  decoder opcode: 0 idle, 97 wrA, 98 wrB, 99 rdA, 100 rdB, 101 sum, 102 avg, 103 man, 104 euc
op_finished  out  1  one-cycle done pulse to decoder
rx_data  in  8  received UART byte
rx_valid  in  1  one-cycle strobe, rx_data valid
tx_data  out  8  byte to transmit
tx_start  out  1  one-cycle transmit request
tx_busy  in  1  UART transmitter busy
mem_addr  out  AW  shared address to BRAM A and B
mem_wdata  out  8  write data
mem_we_a  out  1  write enable BRAM A
mem_we_b  out  1  write enable BRAM B
mem_rdata_a  in  8  BRAM A read data, 1-cycle latency
mem_rdata_b  in  8  BRAM B read data, 1-cycle latency
elem_result  in  8*ELEM_BYTES  combinational ALU result (sum/avg) of current rdata pair
acc_clr  out  1  one-cycle clear of distance accumulator
acc_en  out  1  one-cycle accumulate strobe, current rdata pair valid
acc_done  in  1  one-cycle pulse, acc_result final (after sqrt for euc)
acc_result  in  RES_W  distance result

Behaviour:
- All outputs registered. Reset (rst_n=0, async): state IDLE, idx=0, armed=0, every output 0.
- armed sets whenever op==0. It prevents restarting on the stale opcode present during the cycle after op_finished.
- IDLE: op is sampled only here, and only when armed=1. A valid opcode clears armed, sets idx=0 and branches; any other value is ignored. Opcode changes outside IDLE are ignored.
- Write (97/98), WR_WAIT: rx_valid ignored in every other state. On rx_valid, next cycle drives mem_addr=idx, mem_wdata=rx_data, and mem_we_a (97) or mem_we_b (98) high for exactly 1 cycle. If idx==N-1 go DONE, else idx+1 and stay in WR_WAIT.
- Element loop for read/sum/avg/dist: RD_ADDR drives mem_addr=idx → RD_LAT (1 cycle) → RD_DATA samples rdata.
  - 99: load mem_rdata_a into 1-byte TX buffer.
  - 100: load mem_rdata_b into 1-byte TX buffer.
  - 101/102: load elem_result into ELEM_BYTES buffer.
  - 103/104: acc_en=1 for 1 cycle, no TX.
- Distance ops: acc_clr pulses 1 cycle on leaving IDLE, before the first acc_en.
- TX sub-sequence:
  - TX_SEND waits for tx_busy==0, then pulses tx_start with tx_data=buffer MSB byte.
  - TX_HOLD ignores tx_busy for 1 cycle; UART raises busy within 1 cycle.
  - TX_WAIT waits for tx_busy==0, shifts buffer left 8 bits, repeats until all bytes are sent.
- After each element: if idx==N-1 → (dist: ACC_WAIT; else DONE), else idx+1 → RD_ADDR.
- ACC_WAIT: on acc_done, load acc_result into RES_BYTES buffer, run TX sub-sequence, then DONE. Distance results are sent once, never per element.
- DONE: op_finished=1 for exactly 1 cycle → IDLE. Outputs return to 0 except mem_addr, which holds.
- idx wraps never: terminal count is N-1. The counter is AW bits wide and never exceeds N-1.
- Reset mid-operation: immediate abort with no op_finished. BRAM contents already written stay. A TX byte already started completes inside the UART.
- acc_done outside ACC_WAIT is ignored. tx_busy high at TX_SEND stalls indefinitely; no timeout.

Test Plan:
- N=4, op=97, rx bytes 0x11,0x22,0x33,0x44 with gaps → mem_we_a pulses at addr 0..3 with those data; op_finished 1 cycle after last write; mem_we_b never high.
- After the test-1 write, op=99 held, UART model busy 10 cycles per byte → tx_start 4 times with 0x11,0x22,0x33,0x44; no tx_start while tx_busy=1; single op_finished.
- A={1,2,3,4}, B={10,20,30,40}, op=101, elem_result=A+B zero-extended → 8 TX bytes 00 0B 00 16 00 21 00 2C.
- op=103, acc model returns 0x00006C three cycles after the 4th acc_en → acc_clr once before first acc_en; exactly 4 acc_en; TX 00 00 6C; op_finished.
- op held at 98 for 3 cycles after op_finished → no restart. op=0 then 98 → new write op starts. op=55 in IDLE → ignored.
- rst_n low during 2nd element of op=101 → all outputs 0 asynchronously; no op_finished; op=101 after re-arm restarts from idx=0.

Source files
------------

// File: rtl/vec_op_sequencer_if.sv
// Bundles every signal between the operation sequencer and its
// surroundings: decoder opcode/done, UART RX/TX, the two vector BRAMs
// and the element ALU / distance accumulator.
interface vec_op_sequencer_if #(
    parameter int AW         = 10,
    parameter int ELEM_BYTES = 2,
    parameter int RES_W      = 24
);
    logic [7:0]              op;
    logic                    op_finished;
    logic [7:0]              rx_data;
    logic                    rx_valid;
    logic [7:0]              tx_data;
    logic                    tx_start;
    logic                    tx_busy;
    logic [AW-1:0]           mem_addr;
    logic [7:0]              mem_wdata;
    logic                    mem_we_a;
    logic                    mem_we_b;
    logic [7:0]              mem_rdata_a;
    logic [7:0]              mem_rdata_b;
    logic [8*ELEM_BYTES-1:0] elem_result;
    logic                    acc_clr;
    logic                    acc_en;
    logic                    acc_done;
    logic [RES_W-1:0]        acc_result;

    // Sequencer side.
    modport master (
        input  op, rx_data, rx_valid, tx_busy, mem_rdata_a, mem_rdata_b,
               elem_result, acc_done, acc_result,
        output op_finished, tx_data, tx_start, mem_addr, mem_wdata,
               mem_we_a, mem_we_b, acc_clr, acc_en
    );

    // Environment side: decoder, UART, BRAMs, ALU and accumulator.
    modport slave (
        output op, rx_data, rx_valid, tx_busy, mem_rdata_a, mem_rdata_b,
               elem_result, acc_done, acc_result,
        input  op_finished, tx_data, tx_start, mem_addr, mem_wdata,
               mem_we_a, mem_we_b, acc_clr, acc_en
    );
endinterface

// File: rtl/vec_op_sequencer.sv
// Vector operation sequencer: runs one decoder opcode to completion by
// stepping BRAM addresses, moving UART bytes in/out and strobing the
// distance accumulator, then pulses op_finished for one cycle.
module vec_op_sequencer #(
    parameter int N          = 1024,
    parameter int AW         = $clog2(N),
    parameter int ELEM_BYTES = 2,
    parameter int RES_W      = 24,
    parameter int RES_BYTES  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    vec_op_sequencer_if.master bus
);
    localparam int ELEM_W    = 8 * ELEM_BYTES;
    localparam int BUF_BYTES = (ELEM_BYTES > RES_BYTES) ? ELEM_BYTES : RES_BYTES;
    localparam int BUF_W     = 8 * BUF_BYTES;
    localparam int CW        = $clog2(BUF_BYTES + 1);
    // Left-justification shifts so the first byte to send sits at the top.
    localparam int SH_BYTE   = BUF_W - 8;
    localparam int SH_ELEM   = BUF_W - ELEM_W;
    localparam int SH_RES    = BUF_W - 8 * RES_BYTES;

    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);
    localparam logic [AW-1:0] IDX_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [7:0] OP_NONE = 8'd0;
    localparam logic [7:0] OP_WRA  = 8'd97;
    localparam logic [7:0] OP_WRB  = 8'd98;
    localparam logic [7:0] OP_RDA  = 8'd99;
    localparam logic [7:0] OP_RDB  = 8'd100;
    localparam logic [7:0] OP_SUM  = 8'd101;
    localparam logic [7:0] OP_AVG  = 8'd102;
    localparam logic [7:0] OP_MAN  = 8'd103;
    localparam logic [7:0] OP_EUC  = 8'd104;

    typedef enum logic [3:0] {
        IDLE,
        WR_WAIT,
        RD_ADDR,
        RD_LAT,
        RD_DATA,
        TX_SEND,
        TX_HOLD,
        TX_WAIT,
        ACC_WAIT,
        DONE
    } state_t;

    state_t           state_r;
    logic [AW-1:0]    idx_r;
    logic             armed_r;
    logic [7:0]       op_r;
    logic [BUF_W-1:0] txbuf_r;
    logic [CW-1:0]    txcnt_r;
    logic             is_dist_s;

    // Distance opcodes send one result at the end instead of per-element data.
    assign is_dist_s = (op_r == OP_MAN) || (op_r == OP_EUC);

    // Sequencer FSM: state, element index, TX shifter and every registered output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= IDLE;
            idx_r           <= {AW{1'b0}};
            armed_r         <= 1'b0;
            op_r            <= 8'd0;
            txbuf_r         <= {BUF_W{1'b0}};
            txcnt_r         <= {CW{1'b0}};
            bus.op_finished <= 1'b0;
            bus.tx_data     <= 8'd0;
            bus.tx_start    <= 1'b0;
            bus.mem_addr    <= {AW{1'b0}};
            bus.mem_wdata   <= 8'd0;
            bus.mem_we_a    <= 1'b0;
            bus.mem_we_b    <= 1'b0;
            bus.acc_clr     <= 1'b0;
            bus.acc_en      <= 1'b0;
        end else begin
            // Strobes and data outputs idle at zero; mem_addr holds.
            bus.op_finished <= 1'b0;
            bus.tx_data     <= 8'd0;
            bus.tx_start    <= 1'b0;
            bus.mem_wdata   <= 8'd0;
            bus.mem_we_a    <= 1'b0;
            bus.mem_we_b    <= 1'b0;
            bus.acc_clr     <= 1'b0;
            bus.acc_en      <= 1'b0;

            // Re-arm only once the decoder has dropped back to idle opcode.
            if (bus.op == OP_NONE) begin
                armed_r <= 1'b1;
            end

            case (state_r)
                IDLE: begin
                    if (armed_r) begin
                        case (bus.op)
                            OP_WRA, OP_WRB: begin
                                op_r    <= bus.op;
                                idx_r   <= {AW{1'b0}};
                                armed_r <= 1'b0;
                                state_r <= WR_WAIT;
                            end
                            OP_RDA, OP_RDB, OP_SUM, OP_AVG: begin
                                op_r    <= bus.op;
                                idx_r   <= {AW{1'b0}};
                                armed_r <= 1'b0;
                                state_r <= RD_ADDR;
                            end
                            OP_MAN, OP_EUC: begin
                                op_r        <= bus.op;
                                idx_r       <= {AW{1'b0}};
                                armed_r     <= 1'b0;
                                bus.acc_clr <= 1'b1;
                                state_r     <= RD_ADDR;
                            end
                            default: begin
                                state_r <= IDLE;
                            end
                        endcase
                    end
                end

                WR_WAIT: begin
                    if (bus.rx_valid) begin
                        bus.mem_addr  <= idx_r;
                        bus.mem_wdata <= bus.rx_data;
                        bus.mem_we_a  <= (op_r == OP_WRA);
                        bus.mem_we_b  <= (op_r == OP_WRB);
                        if (idx_r == LAST_IDX) begin
                            state_r <= DONE;
                        end else begin
                            idx_r <= idx_r + IDX_ONE;
                        end
                    end
                end

                RD_ADDR: begin
                    bus.mem_addr <= idx_r;
                    state_r      <= RD_LAT;
                end

                RD_LAT: begin
                    state_r <= RD_DATA;
                end

                RD_DATA: begin
                    case (op_r)
                        OP_RDA: begin
                            txbuf_r <= BUF_W'(bus.mem_rdata_a) << SH_BYTE;
                            txcnt_r <= CNT_ONE;
                            state_r <= TX_SEND;
                        end
                        OP_RDB: begin
                            txbuf_r <= BUF_W'(bus.mem_rdata_b) << SH_BYTE;
                            txcnt_r <= CNT_ONE;
                            state_r <= TX_SEND;
                        end
                        OP_SUM, OP_AVG: begin
                            txbuf_r <= BUF_W'(bus.elem_result) << SH_ELEM;
                            txcnt_r <= CW'(ELEM_BYTES);
                            state_r <= TX_SEND;
                        end
                        default: begin
                            // Distance: accumulate this pair, then next element.
                            bus.acc_en <= 1'b1;
                            if (idx_r == LAST_IDX) begin
                                state_r <= ACC_WAIT;
                            end else begin
                                idx_r   <= idx_r + IDX_ONE;
                                state_r <= RD_ADDR;
                            end
                        end
                    endcase
                end

                TX_SEND: begin
                    if (!bus.tx_busy) begin
                        bus.tx_start <= 1'b1;
                        bus.tx_data  <= txbuf_r[BUF_W-1 -: 8];
                        state_r      <= TX_HOLD;
                    end
                end

                TX_HOLD: begin
                    // UART needs a cycle to raise busy after tx_start.
                    state_r <= TX_WAIT;
                end

                TX_WAIT: begin
                    if (!bus.tx_busy) begin
                        txbuf_r <= txbuf_r << 8;
                        if (txcnt_r == CNT_ONE) begin
                            if (is_dist_s || (idx_r == LAST_IDX)) begin
                                state_r <= DONE;
                            end else begin
                                idx_r   <= idx_r + IDX_ONE;
                                state_r <= RD_ADDR;
                            end
                        end else begin
                            txcnt_r <= txcnt_r - CNT_ONE;
                            state_r <= TX_SEND;
                        end
                    end
                end

                ACC_WAIT: begin
                    if (bus.acc_done) begin
                        txbuf_r <= BUF_W'(bus.acc_result) << SH_RES;
                        txcnt_r <= CW'(RES_BYTES);
                        state_r <= TX_SEND;
                    end
                end

                DONE: begin
                    bus.op_finished <= 1'b1;
                    state_r         <= IDLE;
                end

                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vec_op_sequencer.sv
// Directed bench for vec_op_sequencer with N=4: BRAM, UART and
// accumulator behavioural models plus hand-computed expected values.
module tb_vec_op_sequencer;
    localparam int N          = 4;
    localparam int AW         = 2;
    localparam int ELEM_BYTES = 2;
    localparam int RES_W      = 24;
    localparam int RES_BYTES  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vec_op_sequencer_if #(.AW(AW), .ELEM_BYTES(ELEM_BYTES), .RES_W(RES_W)) bus ();

    vec_op_sequencer #(
        .N(N), .AW(AW), .ELEM_BYTES(ELEM_BYTES), .RES_W(RES_W), .RES_BYTES(RES_BYTES)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // ---------------- environment models ----------------
    logic [7:0] mem_a [0:N-1];
    logic [7:0] mem_b [0:N-1];

    // BRAM pair: synchronous write, 1-cycle read latency.
    always @(posedge clk) begin
        if (bus.mem_we_a) mem_a[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_we_b) mem_b[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata_a <= mem_a[bus.mem_addr];
        bus.mem_rdata_b <= mem_b[bus.mem_addr];
    end
    assign bus.elem_result = {8'h00, bus.mem_rdata_a} + {8'h00, bus.mem_rdata_b};

    // UART transmitter: busy for 10 cycles after each tx_start.
    int busy_cnt = 0;
    always @(posedge clk) begin
        if (bus.tx_start) busy_cnt <= 10;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign bus.tx_busy = (busy_cnt != 0);

    // Accumulator: acc_done three cycles after the N-th acc_en, fixed result.
    int   acc_cnt = 0;
    int   acc_dly = 0;
    logic acc_done_q = 1'b0;
    always @(posedge clk) begin
        acc_done_q <= 1'b0;
        if (bus.acc_clr) acc_cnt <= 0;
        else if (bus.acc_en) begin
            acc_cnt <= acc_cnt + 1;
            if (acc_cnt == N - 1) acc_dly <= 3;
        end
        if (acc_dly > 0) begin
            acc_dly <= acc_dly - 1;
            if (acc_dly == 1) acc_done_q <= 1'b1;
        end
    end
    assign bus.acc_done   = acc_done_q;
    assign bus.acc_result = 24'h00006C;

    // ---------------- event monitor (mid-cycle sampling) ----------------
    int         cyc = 0;
    int         fin_n = 0, fin_cyc = 0;
    int         wr_n = 0, tx_n = 0, busy_viol = 0;
    int         clr_n = 0, clr_cyc = 0, en_n = 0;
    logic [7:0] wr_addr [0:63];
    logic [7:0] wr_data [0:63];
    logic       wr_isb  [0:63];
    int         wr_cyc  [0:63];
    logic [7:0] tx_log  [0:63];
    int         en_cyc  [0:63];

    // Logs every DUT strobe with the cycle it appeared in.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bus.op_finished) begin
            fin_n   <= fin_n + 1;
            fin_cyc <= cyc;
        end
        if ((bus.mem_we_a || bus.mem_we_b) && wr_n < 64) begin
            wr_addr[wr_n] <= 8'(bus.mem_addr);
            wr_data[wr_n] <= bus.mem_wdata;
            wr_isb[wr_n]  <= bus.mem_we_b;
            wr_cyc[wr_n]  <= cyc;
            wr_n          <= wr_n + 1;
        end
        if (bus.tx_start && tx_n < 64) begin
            tx_log[tx_n] <= bus.tx_data;
            tx_n         <= tx_n + 1;
        end
        if (bus.tx_start && bus.tx_busy) busy_viol <= busy_viol + 1;
        if (bus.acc_clr) begin
            clr_n   <= clr_n + 1;
            clr_cyc <= cyc;
        end
        if (bus.acc_en && en_n < 64) begin
            en_cyc[en_n] <= cyc;
            en_n         <= en_n + 1;
        end
    end

    // ---------------- checking helpers ----------------
    int checks = 0;
    int passes = 0;
    int fails  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send_rx(input logic [7:0] b);
        repeat (3) tick();
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    task automatic wait_fin(input string tag, input int budget);
        int base;
        int k;
        base = fin_n;
        k = 0;
        while (fin_n == base && k < budget) begin
            tick();
            k++;
        end
        check({tag, " finished"}, 32'(fin_n != base), 32'd1);
    endtask

    task automatic check_tx(input string tag, input int base, input int cnt, input logic [63:0] exp);
        check({tag, " tx count"}, 32'(tx_n - base), 32'(cnt));
        for (int i = 0; i < cnt; i++) begin
            if (base + i < 64)
                check($sformatf("%s tx byte %0d", tag, i), 32'(tx_log[base + i]),
                      32'(exp[8*(cnt-1-i) +: 8]));
        end
    endtask

    task automatic check_wr(input string tag, input int base, input logic isb, input logic [31:0] exp);
        check({tag, " write count"}, 32'(wr_n - base), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s addr %0d", tag, i), 32'(wr_addr[base + i]), 32'(i));
            check($sformatf("%s data %0d", tag, i), 32'(wr_data[base + i]), 32'(exp[8*(3-i) +: 8]));
            check($sformatf("%s bank %0d", tag, i), 32'(wr_isb[base + i]), 32'(isb));
        end
    endtask

    task automatic write_vec(input string tag, input logic [7:0] opc, input logic [31:0] v);
        int wb;
        wb = wr_n;
        bus.op = opc;
        for (int i = 0; i < 4; i++) send_rx(v[8*(3-i) +: 8]);
        wait_fin(tag, 50);
        check_wr(tag, wb, (opc == 8'd98), v);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int wb, fb, tb, cb, eb, k;
        bus.op       = 8'd0;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        rst_n        = 1'b0;
        repeat (2) tick();

        // Reset state.
        check("reset op_finished", 32'(bus.op_finished), 32'd0);
        check("reset strobes", 32'({bus.tx_start, bus.mem_we_a, bus.mem_we_b, bus.acc_clr, bus.acc_en}), 32'd0);
        check("reset data", 32'({bus.tx_data, bus.mem_wdata, 6'(bus.mem_addr)}), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Write A with gaps; op_finished one cycle after the last write.
        fb = fin_n;
        wb = wr_n;
        write_vec("wrA", 8'd97, 32'h11223344);
        check("wrA fin latency", 32'(fin_cyc - wr_cyc[wb + 3]), 32'd1);
        bus.op = 8'd0;
        repeat (3) tick();
        check("wrA single fin", 32'(fin_n - fb), 32'd1);

        // Read A back over a slow UART.
        fb = fin_n;
        tb = tx_n;
        bus.op = 8'd99;
        wait_fin("rdA", 300);
        bus.op = 8'd0;
        repeat (3) tick();
        check_tx("rdA", tb, 4, 64'h11223344);
        check("rdA start while busy", 32'(busy_viol), 32'd0);
        check("rdA single fin", 32'(fin_n - fb), 32'd1);

        // Load A={1,2,3,4}; B={10,20,30,40} with stale opcode held afterwards.
        write_vec("wrA2", 8'd97, 32'h01020304);
        bus.op = 8'd0;
        tick();
        write_vec("wrB", 8'd98, 32'h0A141E28);
        wb = wr_n;
        fb = fin_n;
        repeat (3) tick();
        send_rx(8'h77);
        repeat (3) tick();
        check("stale op no write", 32'(wr_n - wb), 32'd0);
        check("stale op no fin", 32'(fin_n - fb), 32'd0);
        bus.op = 8'd0;
        tick();
        write_vec("wrB again", 8'd98, 32'h0A141E28);
        bus.op = 8'd0;
        tick();

        // Invalid opcode in IDLE is ignored.
        wb = wr_n;
        fb = fin_n;
        tb = tx_n;
        bus.op = 8'd55;
        send_rx(8'h66);
        repeat (5) tick();
        check("op55 no write", 32'(wr_n - wb), 32'd0);
        check("op55 no fin", 32'(fin_n - fb), 32'd0);
        check("op55 no tx", 32'(tx_n - tb), 32'd0);
        bus.op = 8'd0;
        tick();

        // Element sum, two bytes per element MSB first.
        tb = tx_n;
        bus.op = 8'd101;
        wait_fin("sum", 600);
        bus.op = 8'd0;
        tick();
        check_tx("sum", tb, 8, 64'h000B_0016_0021_002C);

        // Manhattan distance: clear, 4 accumulates, one 3-byte result.
        tb = tx_n;
        cb = clr_n;
        eb = en_n;
        fb = fin_n;
        bus.op = 8'd103;
        wait_fin("man", 400);
        bus.op = 8'd0;
        repeat (2) tick();
        check("man acc_clr count", 32'(clr_n - cb), 32'd1);
        check("man acc_en count", 32'(en_n - eb), 32'd4);
        check("man clr before en", 32'(clr_cyc < en_cyc[eb]), 32'd1);
        check_tx("man", tb, 3, 64'h00006C);
        check("man single fin", 32'(fin_n - fb), 32'd1);

        // Reset during the second element of a sum.
        tb = tx_n;
        bus.op = 8'd101;
        k = 0;
        while ((tx_n - tb) < 3 && k < 200) begin
            tick();
            k++;
        end
        check("sum reached elem 2", 32'((tx_n - tb) >= 3), 32'd1);
        fb = fin_n;
        rst_n = 1'b0;
        #1;
        check("async reset strobes", 32'({bus.op_finished, bus.tx_start, bus.mem_we_a, bus.mem_we_b, bus.acc_clr, bus.acc_en}), 32'd0);
        check("async reset data", 32'({bus.tx_data, bus.mem_wdata, 6'(bus.mem_addr)}), 32'd0);
        repeat (3) tick();
        check("reset no fin", 32'(fin_n - fb), 32'd0);
        rst_n = 1'b1;
        bus.op = 8'd0;
        repeat (2) tick();
        tb = tx_n;
        bus.op = 8'd101;
        wait_fin("sum restart", 600);
        bus.op = 8'd0;
        tick();
        check_tx("sum restart", tb, 8, 64'h000B_0016_0021_002C);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
